// File: rtl/jtopl_pkg.sv
// Shared constants for the JTOPL log-sine stage: waveform selects and the
// quarter-wave log-sine table (fixed 256x12, or computed for other sizes).
package jtopl_pkg;

   typedef enum logic [2:0] {
      WAVE_SINE   = 3'd0,
      WAVE_HALF   = 3'd1,
      WAVE_ABS    = 3'd2,
      WAVE_QPULSE = 3'd3,
      WAVE_ALT    = 3'd4,
      WAVE_ALTABS = 3'd5,
      WAVE_SQR    = 3'd6,
      WAVE_DSQR   = 3'd7
   } wave_e;

   localparam real PI = 3.14159265358979323846;

   // round(-log2(sin((2q+1)*pi/1024))*256), q = 0..255
   localparam logic [11:0] LOGSIN_TBL [256] = '{
      12'd2137, 12'd1731, 12'd1543, 12'd1419, 12'd1326, 12'd1252, 12'd1190, 12'd1137,
      12'd1091, 12'd1050, 12'd1013, 12'd979,  12'd949,  12'd920,  12'd894,  12'd869,
      12'd846,  12'd825,  12'd804,  12'd785,  12'd767,  12'd749,  12'd732,  12'd717,
      12'd701,  12'd687,  12'd672,  12'd659,  12'd646,  12'd633,  12'd621,  12'd609,
      12'd598,  12'd587,  12'd576,  12'd566,  12'd556,  12'd546,  12'd536,  12'd527,
      12'd518,  12'd509,  12'd501,  12'd492,  12'd484,  12'd476,  12'd468,  12'd461,
      12'd453,  12'd446,  12'd439,  12'd432,  12'd425,  12'd418,  12'd411,  12'd405,
      12'd399,  12'd392,  12'd386,  12'd380,  12'd375,  12'd369,  12'd363,  12'd358,
      12'd352,  12'd347,  12'd341,  12'd336,  12'd331,  12'd326,  12'd321,  12'd316,
      12'd311,  12'd307,  12'd302,  12'd297,  12'd293,  12'd289,  12'd284,  12'd280,
      12'd276,  12'd271,  12'd267,  12'd263,  12'd259,  12'd255,  12'd251,  12'd248,
      12'd244,  12'd240,  12'd236,  12'd233,  12'd229,  12'd226,  12'd222,  12'd219,
      12'd215,  12'd212,  12'd209,  12'd205,  12'd202,  12'd199,  12'd196,  12'd193,
      12'd190,  12'd187,  12'd184,  12'd181,  12'd178,  12'd175,  12'd172,  12'd169,
      12'd167,  12'd164,  12'd161,  12'd159,  12'd156,  12'd153,  12'd151,  12'd148,
      12'd146,  12'd143,  12'd141,  12'd138,  12'd136,  12'd134,  12'd131,  12'd129,
      12'd127,  12'd125,  12'd122,  12'd120,  12'd118,  12'd116,  12'd114,  12'd112,
      12'd110,  12'd108,  12'd106,  12'd104,  12'd102,  12'd100,  12'd98,   12'd96,
      12'd94,   12'd92,   12'd91,   12'd89,   12'd87,   12'd85,   12'd83,   12'd82,
      12'd80,   12'd78,   12'd77,   12'd75,   12'd74,   12'd72,   12'd70,   12'd69,
      12'd67,   12'd66,   12'd64,   12'd63,   12'd62,   12'd60,   12'd59,   12'd57,
      12'd56,   12'd55,   12'd53,   12'd52,   12'd51,   12'd49,   12'd48,   12'd47,
      12'd46,   12'd45,   12'd43,   12'd42,   12'd41,   12'd40,   12'd39,   12'd38,
      12'd37,   12'd36,   12'd35,   12'd34,   12'd33,   12'd32,   12'd31,   12'd30,
      12'd29,   12'd28,   12'd27,   12'd26,   12'd25,   12'd24,   12'd23,   12'd23,
      12'd22,   12'd21,   12'd20,   12'd20,   12'd19,   12'd18,   12'd17,   12'd17,
      12'd16,   12'd15,   12'd15,   12'd14,   12'd13,   12'd13,   12'd12,   12'd12,
      12'd11,   12'd10,   12'd10,   12'd9,    12'd9,    12'd8,    12'd8,    12'd7,
      12'd7,    12'd7,    12'd6,    12'd6,    12'd5,    12'd5,    12'd5,    12'd4,
      12'd4,    12'd4,    12'd3,    12'd3,    12'd3,    12'd2,    12'd2,    12'd2,
      12'd2,    12'd1,    12'd1,    12'd1,    12'd1,    12'd1,    12'd1,    12'd1,
      12'd0,    12'd0,    12'd0,    12'd0,    12'd0,    12'd0,    12'd0,    12'd0
   };

   // Elaboration-time entry for non-default table sizes, clipped to dw bits.
   function automatic int logsin_entry(input int aw, input int dw, input int idx);
      real x, l;
      int  r;
      x = $sin((2.0 * $itor(idx) + 1.0) * PI / (2.0 ** (aw + 2)));
      l = -($ln(x) / $ln(2.0)) * 256.0;
      r = $rtoi(l + 0.5);
      if (r > (2 ** dw) - 1) r = (2 ** dw) - 1;
      return r;
   endfunction

endpackage

// File: rtl/jtopl_logsin_wave_if.sv
// Sample bus of the log-sine stage: phase/wave/att in, log magnitude out.
interface jtopl_logsin_wave_if #(
   parameter int PHASE_W = 10,
   parameter int ATT_W   = 9,
   parameter int OUT_W   = 13
);
   logic               in_valid;
   logic [PHASE_W-1:0] phase;
   logic [2:0]         wave;
   logic [ATT_W-1:0]   att;
   logic               out_valid;
   logic [OUT_W-1:0]   out_log;
   logic               out_sign;
   logic               out_mute;

   modport master (
      output in_valid, phase, wave, att,
      input  out_valid, out_log, out_sign, out_mute
   );

   modport slave (
      input  in_valid, phase, wave, att,
      output out_valid, out_log, out_sign, out_mute
   );
endinterface

// File: rtl/jtopl_logsin_rom.sv
// Quarter-wave log-sine ROM with registered, cen-qualified read data.
module jtopl_logsin_rom
   import jtopl_pkg::*;
#(
   parameter int AW = 8,
   parameter int DW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] data
);

   generate
      if (AW == 8 && DW == 12) begin : g_fixed
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   data <= '0;
            else if (cen) data <= LOGSIN_TBL[addr];
         end
      end else begin : g_calc
         typedef logic [DW-1:0] tbl_t [2**AW];

         function automatic tbl_t build();
            tbl_t t;
            for (int unsigned i = 0; i < 2**AW; i++)
               t[i] = DW'(logsin_entry(AW, DW, int'(i)));
            return t;
         endfunction

         localparam tbl_t TBL = build();

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   data <= '0;
            else if (cen) data <= TBL[addr];
         end
      end
   endgenerate

endmodule

// File: rtl/jtopl_logsin_wave.sv
// Phase-to-log-sine stage: wave decode, ROM lookup and attenuation add in a
// 3-stage cen pipeline. Define JTOPL_OPL3_WAVES_EN for OPL3 waveforms 4..7.
module jtopl_logsin_wave
   import jtopl_pkg::*;
#(
   parameter int PHASE_W  = 10,
   parameter int LOGSIN_W = 12,
   parameter int ATT_W    = 9,
   parameter int OUT_W    = 13
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cen,
   jtopl_logsin_wave_if.slave bus
);

   localparam int LUT_AW = PHASE_W - 2;

   // ---------------- stage 1: decode ----------------
   wave_e             wsel;
   logic              s, m;
   logic [LUT_AW-1:0] q_d;
   logic              sign_d, mute_d;

`ifdef JTOPL_OPL3_WAVES_EN
   localparam logic [31:0] LOG_MAX = 32'((1 << LOGSIN_W) - 1);
   logic [PHASE_W-1:0]  ph2;
   logic [31:0]         dsq;
   logic                byp_d;
   logic [LOGSIN_W-1:0] blog_d;
`else
   logic unused_wave2;
   assign unused_wave2 = bus.wave[2];
`endif

   always_comb begin
      s      = bus.phase[PHASE_W-1];
      m      = bus.phase[PHASE_W-2];
      q_d    = m ? ~bus.phase[LUT_AW-1:0] : bus.phase[LUT_AW-1:0];
      sign_d = 1'b0;
      mute_d = 1'b0;
`ifdef JTOPL_OPL3_WAVES_EN
      wsel   = wave_e'(bus.wave);
      ph2    = {bus.phase[PHASE_W-2:0], 1'b0};
      dsq    = 32'({(s ? ~bus.phase[PHASE_W-2:0] : bus.phase[PHASE_W-2:0]), 3'b000});
      byp_d  = 1'b0;
      blog_d = '0;
`else
      wsel   = wave_e'({1'b0, bus.wave[1:0]});
`endif
      case (wsel)
         WAVE_SINE:   sign_d = s;
         WAVE_HALF:   mute_d = s;
         WAVE_ABS:    ;
         WAVE_QPULSE: mute_d = m;
`ifdef JTOPL_OPL3_WAVES_EN
         // Double-speed phase; muted on the original negative half.
         WAVE_ALT, WAVE_ALTABS: begin
            mute_d = s;
            sign_d = (wsel == WAVE_ALT) ? ph2[PHASE_W-1] : 1'b0;
            q_d    = ph2[PHASE_W-2] ? ~ph2[LUT_AW-1:0] : ph2[LUT_AW-1:0];
         end
         WAVE_SQR: begin
            byp_d  = 1'b1;
            sign_d = s;
         end
         WAVE_DSQR: begin
            byp_d  = 1'b1;
            sign_d = s;
            blog_d = (dsq > LOG_MAX) ? '1 : dsq[LOGSIN_W-1:0];
         end
`endif
         default: ;
      endcase
   end

   logic              v1, sign1, mute1;
   logic [LUT_AW-1:0] q1;
   logic [ATT_W-1:0]  att1;
`ifdef JTOPL_OPL3_WAVES_EN
   logic                byp1;
   logic [LOGSIN_W-1:0] blog1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         q1    <= '0;
         sign1 <= 1'b0;
         mute1 <= 1'b0;
         att1  <= '0;
`ifdef JTOPL_OPL3_WAVES_EN
         byp1  <= 1'b0;
         blog1 <= '0;
`endif
      end else if (cen) begin
         v1    <= bus.in_valid;
         q1    <= q_d;
         sign1 <= sign_d;
         mute1 <= mute_d;
         att1  <= bus.att;
`ifdef JTOPL_OPL3_WAVES_EN
         byp1  <= byp_d;
         blog1 <= blog_d;
`endif
      end
   end

   // ---------------- stage 2: ROM read ----------------
   logic [LOGSIN_W-1:0] rdata;
   logic                v2, sign2, mute2;
   logic [ATT_W-1:0]    att2;
`ifdef JTOPL_OPL3_WAVES_EN
   logic                byp2;
   logic [LOGSIN_W-1:0] blog2;
`endif

   jtopl_logsin_rom #(
      .AW (LUT_AW),
      .DW (LOGSIN_W)
   ) u_rom (
      .clk   (clk),
      .rst_n (rst_n),
      .cen   (cen),
      .addr  (q1),
      .data  (rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2    <= 1'b0;
         sign2 <= 1'b0;
         mute2 <= 1'b0;
         att2  <= '0;
`ifdef JTOPL_OPL3_WAVES_EN
         byp2  <= 1'b0;
         blog2 <= '0;
`endif
      end else if (cen) begin
         v2    <= v1;
         sign2 <= sign1;
         mute2 <= mute1;
         att2  <= att1;
`ifdef JTOPL_OPL3_WAVES_EN
         byp2  <= byp1;
         blog2 <= blog1;
`endif
      end
   end

   // ---------------- stage 3: attenuation add ----------------
   logic [LOGSIN_W-1:0] lg;
   logic [OUT_W:0]      sum;
   logic [OUT_W-1:0]    log_d;

   always_comb begin
`ifdef JTOPL_OPL3_WAVES_EN
      lg = byp2 ? blog2 : rdata;
`else
      lg = rdata;
`endif
      sum = (OUT_W+1)'(lg) + ((OUT_W+1)'(att2) << 3);
      if (mute2 || sum[OUT_W]) log_d = '1;
      else                     log_d = sum[OUT_W-1:0];
   end

   logic             ov, osign, omute;
   logic [OUT_W-1:0] olog;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ov    <= 1'b0;
         olog  <= '1;
         osign <= 1'b0;
         omute <= 1'b1;
      end else if (cen) begin
         ov    <= v2;
         olog  <= log_d;
         osign <= sign2;
         omute <= mute2;
      end
   end

   assign bus.out_valid = ov;
   assign bus.out_log   = olog;
   assign bus.out_sign  = osign;
   assign bus.out_mute  = omute;

endmodule

// File: tb/tb_jtopl_logsin_wave.sv
// Directed bench for jtopl_logsin_wave: vector table plus cen-gating and
// mid-flight reset sequences, on OUT_W=13 and OUT_W=12 instances.
module tb_jtopl_logsin_wave;

   logic       clk = 1'b0;
   logic       rst_n, cen;
   logic       in_valid;
   logic [9:0] phase;
   logic [2:0] wave;
   logic [8:0] att;
   int         checks = 0;
   int         errors = 0;

   jtopl_logsin_wave_if #(.PHASE_W(10), .ATT_W(9), .OUT_W(13)) bus ();
   jtopl_logsin_wave_if #(.PHASE_W(10), .ATT_W(9), .OUT_W(12)) bus12 ();

   assign bus.in_valid   = in_valid;
   assign bus.phase      = phase;
   assign bus.wave       = wave;
   assign bus.att        = att;
   assign bus12.in_valid = in_valid;
   assign bus12.phase    = phase;
   assign bus12.wave     = wave;
   assign bus12.att      = att;

   jtopl_logsin_wave #(.PHASE_W(10), .LOGSIN_W(12), .ATT_W(9), .OUT_W(13)) dut (
      .clk (clk), .rst_n (rst_n), .cen (cen), .bus (bus)
   );

   jtopl_logsin_wave #(.PHASE_W(10), .LOGSIN_W(12), .ATT_W(9), .OUT_W(12)) dut12 (
      .clk (clk), .rst_n (rst_n), .cen (cen), .bus (bus12)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  phase;
      logic [2:0]  wave;
      logic [8:0]  att;
      logic [12:0] log13;
      logic [11:0] log12;
      logic        sign;
      logic        mute;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [9:0] p, input logic [2:0] w, input logic [8:0] a,
                               input logic [12:0] l13, input logic [11:0] l12,
                               input logic sg, input logic mu);
      vec_t v;
      v.phase = p; v.wave = w; v.att = a;
      v.log13 = l13; v.log12 = l12; v.sign = sg; v.mute = mu;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic        mv [3];
      logic [12:0] ml [3];
      logic [9:0]  phs [4];
      logic [12:0] exl [4];
      int          k, outs;

      // ---------- vector table ----------
      vecs.push_back(mk(10'h000, 3'd0, 9'h000, 13'h0859, 12'h859, 1'b0, 1'b0));
      vecs.push_back(mk(10'h0FF, 3'd0, 9'h000, 13'h0000, 12'h000, 1'b0, 1'b0));
      vecs.push_back(mk(10'h100, 3'd0, 9'h000, 13'h0000, 12'h000, 1'b0, 1'b0));
      vecs.push_back(mk(10'h2FF, 3'd0, 9'h000, 13'h0000, 12'h000, 1'b1, 1'b0));
      vecs.push_back(mk(10'h200, 3'd0, 9'h000, 13'h0859, 12'h859, 1'b1, 1'b0));
      vecs.push_back(mk(10'h280, 3'd1, 9'h000, 13'h1FFF, 12'hFFF, 1'b0, 1'b1));
      vecs.push_back(mk(10'h100, 3'd3, 9'h000, 13'h1FFF, 12'hFFF, 1'b0, 1'b1));
      vecs.push_back(mk(10'h300, 3'd2, 9'h000, 13'h0000, 12'h000, 1'b0, 1'b0));
      vecs.push_back(mk(10'h0FF, 3'd0, 9'h1FF, 13'h0FF8, 12'hFF8, 1'b0, 1'b0));
      vecs.push_back(mk(10'h000, 3'd0, 9'h1FF, 13'h1851, 12'hFFF, 1'b0, 1'b0));
      vecs.push_back(mk(10'h3FF, 3'd0, 9'h000, 13'h0859, 12'h859, 1'b1, 1'b0));
      vecs.push_back(mk(10'h080, 3'd0, 9'h010, 13'h00FF, 12'h0FF, 1'b0, 1'b0));
      vecs.push_back(mk(10'h180, 3'd1, 9'h000, 13'h0081, 12'h081, 1'b0, 1'b0));
      vecs.push_back(mk(10'h280, 3'd2, 9'h000, 13'h007F, 12'h07F, 1'b0, 1'b0));
      vecs.push_back(mk(10'h001, 3'd3, 9'h000, 13'h06C3, 12'h6C3, 1'b0, 1'b0));
      vecs.push_back(mk(10'h201, 3'd3, 9'h000, 13'h06C3, 12'h6C3, 1'b0, 1'b0));
      vecs.push_back(mk(10'h300, 3'd3, 9'h1FF, 13'h1FFF, 12'hFFF, 1'b0, 1'b1));
`ifdef JTOPL_OPL3_WAVES_EN
      vecs.push_back(mk(10'h040, 3'd4, 9'h000, 13'h007F, 12'h07F, 1'b0, 1'b0));
      vecs.push_back(mk(10'h140, 3'd4, 9'h000, 13'h007F, 12'h07F, 1'b1, 1'b0));
      vecs.push_back(mk(10'h200, 3'd4, 9'h000, 13'h1FFF, 12'hFFF, 1'b0, 1'b1));
      vecs.push_back(mk(10'h140, 3'd5, 9'h000, 13'h007F, 12'h07F, 1'b0, 1'b0));
      vecs.push_back(mk(10'h200, 3'd6, 9'h000, 13'h0000, 12'h000, 1'b1, 1'b0));
      vecs.push_back(mk(10'h010, 3'd7, 9'h000, 13'h0080, 12'h080, 1'b0, 1'b0));
      vecs.push_back(mk(10'h3F0, 3'd7, 9'h000, 13'h0078, 12'h078, 1'b1, 1'b0));
      vecs.push_back(mk(10'h1FF, 3'd7, 9'h001, 13'h1000, 12'hFFF, 1'b0, 1'b0));
`else
      vecs.push_back(mk(10'h200, 3'd4, 9'h000, 13'h0859, 12'h859, 1'b1, 1'b0));
      vecs.push_back(mk(10'h280, 3'd5, 9'h000, 13'h1FFF, 12'hFFF, 1'b0, 1'b1));
      vecs.push_back(mk(10'h300, 3'd6, 9'h000, 13'h0000, 12'h000, 1'b0, 1'b0));
      vecs.push_back(mk(10'h100, 3'd7, 9'h000, 13'h1FFF, 12'hFFF, 1'b0, 1'b1));
`endif

      // ---------- reset held across cen edges with a valid input ----------
      rst_n = 1'b0; cen = 1'b1; in_valid = 1'b1;
      phase = 10'h000; wave = 3'd0; att = 9'h000;
      step();
      step();
      chk("rst.valid", 32'(bus.out_valid), 32'd0);
      chk("rst.log",   32'(bus.out_log),   32'h1FFF);
      chk("rst.sign",  32'(bus.out_sign),  32'd0);
      chk("rst.mute",  32'(bus.out_mute),  32'd1);
      chk("rst.log12", 32'(bus12.out_log), 32'hFFF);
      rst_n = 1'b1;
      in_valid = 1'b0;

      // ---------- back-to-back table, cen=1 ----------
      for (int i = 0; i < vecs.size() + 2; i++) begin
         if (i < vecs.size()) begin
            in_valid = 1'b1;
            phase = vecs[i].phase; wave = vecs[i].wave; att = vecs[i].att;
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (i >= 2) begin
            chk($sformatf("v%0d.valid", i-2), 32'(bus.out_valid),  32'd1);
            chk($sformatf("v%0d.log",   i-2), 32'(bus.out_log),    32'(vecs[i-2].log13));
            chk($sformatf("v%0d.sign",  i-2), 32'(bus.out_sign),   32'(vecs[i-2].sign));
            chk($sformatf("v%0d.mute",  i-2), 32'(bus.out_mute),   32'(vecs[i-2].mute));
            chk($sformatf("v%0d.log12", i-2), 32'(bus12.out_log),  32'(vecs[i-2].log12));
         end
      end
      step();
      chk("table.drain", 32'(bus.out_valid), 32'd0);

      // ---------- cen pattern 1,0,0 with junk presented on held cycles ----------
      phs[0] = 10'h000; phs[1] = 10'h001; phs[2] = 10'h002; phs[3] = 10'h003;
      exl[0] = 13'h0859; exl[1] = 13'h06C3; exl[2] = 13'h0607; exl[3] = 13'h058B;
      for (int j = 0; j < 3; j++) begin mv[j] = 1'b0; ml[j] = '0; end
      k = 0; outs = 0; wave = 3'd0; att = 9'h000;
      for (int c = 0; c < 21; c++) begin
         cen = (c % 3 == 0);
         if (cen) begin
            in_valid = (k < 4);
            phase = (k < 4) ? phs[k] : 10'h0FF;
         end else begin
            in_valid = 1'b1;
            phase = 10'h0FF;
         end
         step();
         if (cen) begin
            mv[2] = mv[1]; ml[2] = ml[1];
            mv[1] = mv[0]; ml[1] = ml[0];
            mv[0] = (k < 4); ml[0] = (k < 4) ? exl[k] : 13'h0000;
            if (k < 4) k++;
            if (bus.out_valid) outs++;
         end
         chk($sformatf("cen.c%0d.valid", c), 32'(bus.out_valid), 32'(mv[2]));
         if (mv[2]) chk($sformatf("cen.c%0d.log", c), 32'(bus.out_log), 32'(ml[2]));
      end
      chk("cen.count", 32'(outs), 32'd4);

      // ---------- reset with three samples in flight ----------
      cen = 1'b1;
      for (int j = 0; j < 3; j++) begin
         in_valid = 1'b1;
         phase = phs[j];
         step();
      end
      chk("flight.first", 32'(bus.out_log), 32'h0859);
      #2 rst_n = 1'b0;
      #1;
      chk("flight.rst.valid", 32'(bus.out_valid), 32'd0);
      chk("flight.rst.log",   32'(bus.out_log),   32'h1FFF);
      chk("flight.rst.mute",  32'(bus.out_mute),  32'd1);
      in_valid = 1'b1;
      phase = 10'h0FF;
      step();
      chk("flight.hold.valid", 32'(bus.out_valid), 32'd0);
      rst_n = 1'b1;
      phase = 10'h003;
      step();
      in_valid = 1'b0;
      chk("post.e1.valid", 32'(bus.out_valid), 32'd0);
      step();
      chk("post.e2.valid", 32'(bus.out_valid), 32'd0);
      step();
      chk("post.e3.valid", 32'(bus.out_valid), 32'd1);
      chk("post.e3.log",   32'(bus.out_log),   32'h058B);
      step();
      chk("post.e4.valid", 32'(bus.out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
